// File: rtl/ftdi_stream_pkg.sv
// Shared types and helpers for the FTDI stream command/traffic blocks.
package ftdi_stream_pkg;

  localparam int unsigned IN_W   = 8;
  localparam int unsigned OUT_W  = 32;
  localparam int unsigned KEEP_W = 4;
  localparam int unsigned LEN_W  = 32;
  localparam int unsigned CNT_W  = 16;

  localparam logic MODE_INC   = 1'b0;
  localparam logic MODE_CONST = 1'b1;

  localparam logic [0:0] S_HDR  = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  typedef struct packed {
    logic [OUT_W-1:0]  data;
    logic [KEEP_W-1:0] keep;
    logic              last;
  } beat_t;

  // Byte enables for a short final beat; rem[1:0]==0 means a full beat.
  function automatic logic [KEEP_W-1:0] keep_from_rem(input logic [1:0] rem);
    case (rem)
      2'd1:    return 4'b0001;
      2'd2:    return 4'b0011;
      2'd3:    return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/tx_mass_cmd_gen_if.sv
// Command byte stream in, 32-bit beat stream out.
interface tx_mass_cmd_gen_if
  import ftdi_stream_pkg::*;
;
  logic              i_tready;
  logic              i_tvalid;
  logic [IN_W-1:0]   i_tdata;
  logic              o_tready;
  logic              o_tvalid;
  logic [OUT_W-1:0]  o_tdata;
  logic [KEEP_W-1:0] o_tkeep;
  logic              o_tlast;

  modport master (
    output i_tready, o_tvalid, o_tdata, o_tkeep, o_tlast,
    input  i_tvalid, i_tdata, o_tready
  );

  modport slave (
    input  i_tready, o_tvalid, o_tdata, o_tkeep, o_tlast,
    output i_tvalid, i_tdata, o_tready
  );
endinterface

// File: rtl/pattern_beat_src.sv
// Beat generator: walks a transfer of i_len bytes and presents registered beats
// with tkeep/tlast; a new beat is loaded in the same cycle the previous one is taken.
module pattern_beat_src
  import ftdi_stream_pkg::*;
#(
  parameter int unsigned PKT_BYTES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [OUT_W-1:0]  o_data,
  output logic [KEEP_W-1:0] o_keep,
  output logic              o_last,
  output logic              o_done_c
);

  localparam int unsigned           CHUNK_W   = $clog2(PKT_BYTES);
  localparam logic [CHUNK_W-1:0]    CHUNK_END = CHUNK_W'(PKT_BYTES - 4);

  logic               r_active;
  logic               r_mode;
  logic               r_final;
  logic               r_valid;
  logic [LEN_W-1:0]   r_rem;
  logic [LEN_W-1:0]   r_off;
  logic [CHUNK_W-1:0] r_chunk;
  beat_t              r_beat;

  logic               w_load;
  logic               w_full;
  logic               w_final;
  logic [2:0]         w_nbytes;
  beat_t              w_beat;

  // Next beat contents from the remaining count and running offset.
  always_comb begin
    w_beat   = '0;
    w_full   = (r_rem[LEN_W-1:2] != '0);
    w_final  = !w_full || (r_rem == LEN_W'(4));
    w_nbytes = w_full ? 3'd4 : {1'b0, r_rem[1:0]};
    w_load   = r_active && (r_rem != '0) && (!r_valid || i_ready);
    w_beat.keep = w_full ? 4'b1111 : keep_from_rem(r_rem[1:0]);
    w_beat.last = w_final || (r_chunk == CHUNK_END);
    for (int j = 0; j < KEEP_W; j++) begin
      if (w_beat.keep[j]) begin
        w_beat.data[8*j +: 8] = (r_mode == MODE_INC) ? (r_off[7:0] + 8'(j)) : 8'hFF;
      end
    end
  end

  assign o_done_c = r_valid && i_ready && r_final;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
      r_mode   <= 1'b0;
      r_final  <= 1'b0;
      r_valid  <= 1'b0;
      r_rem    <= '0;
      r_off    <= '0;
      r_chunk  <= '0;
      r_beat   <= '0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_mode   <= i_mode;
      r_rem    <= i_len;
      r_off    <= '0;
      r_chunk  <= '0;
    end else begin
      if (w_load) begin
        r_valid <= 1'b1;
        r_beat  <= w_beat;
        r_final <= w_final;
        r_rem   <= r_rem - LEN_W'(w_nbytes);
        r_off   <= r_off + LEN_W'(4);
        r_chunk <= (r_chunk == CHUNK_END) ? '0 : r_chunk + CHUNK_W'(4);
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
      if (o_done_c) begin
        r_active <= 1'b0;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_beat.data;
  assign o_keep  = r_beat.keep;
  assign o_last  = r_beat.last;

endmodule

// File: rtl/tx_mass_cmd_gen.sv
// Command-driven TX traffic generator: parses MODE + 32-bit LEN from the byte
// stream, then streams LEN pattern bytes as 32-bit beats.
module tx_mass_cmd_gen
  import ftdi_stream_pkg::*;
#(
  parameter int unsigned PKT_BYTES   = 4096,
  parameter int unsigned HDR_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  tx_mass_cmd_gen_if.master bus,
  output logic              busy,
  output logic [CNT_W-1:0]  cmd_cnt
);

  localparam int unsigned       TO_W    = (HDR_TIMEOUT > 1) ? $clog2(HDR_TIMEOUT) : 1;
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(HDR_TIMEOUT - 1);

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [2:0]       r_hdr_idx;
  logic [TO_W-1:0]  r_idle;
  logic             r_mode;
  logic [23:0]      r_len_lo;
  logic             r_i_tready;
  logic             r_busy;
  logic [CNT_W-1:0] r_cmd_cnt;

  logic             w_acc;
  logic             w_hdr_last;
  logic             w_start;
  logic             w_done_c;
  logic [LEN_W-1:0] w_len;

  // Next-state: leave S_HDR on a complete non-empty header, return on final beat.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_acc       = bus.i_tvalid && r_i_tready;
    w_len       = {bus.i_tdata, r_len_lo};
    w_hdr_last  = w_acc && (r_hdr_idx == 3'd4);
    case (r_state)
      S_HDR: begin
        if (w_hdr_last && (w_len != '0)) begin
          w_start     = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (w_done_c) begin
          w_state_nxt = S_HDR;
        end
      end
      default: w_state_nxt = S_HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_HDR;
      r_i_tready <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_i_tready <= (w_state_nxt == S_HDR);
      r_busy     <= (w_state_nxt == S_SEND);
    end
  end

  // Header capture; a stalled partial header is dropped after HDR_TIMEOUT idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hdr_idx <= '0;
      r_idle    <= '0;
      r_mode    <= 1'b0;
      r_len_lo  <= '0;
    end else if (w_acc) begin
      r_idle    <= '0;
      r_hdr_idx <= w_hdr_last ? 3'd0 : r_hdr_idx + 3'd1;
      case (r_hdr_idx)
        3'd0:    r_mode          <= bus.i_tdata[0];
        3'd1:    r_len_lo[7:0]   <= bus.i_tdata;
        3'd2:    r_len_lo[15:8]  <= bus.i_tdata;
        3'd3:    r_len_lo[23:16] <= bus.i_tdata;
        default: ;
      endcase
    end else if ((HDR_TIMEOUT != 0) && (r_hdr_idx != 3'd0)) begin
      if (r_idle == TO_LAST) begin
        r_hdr_idx <= '0;
        r_idle    <= '0;
      end else begin
        r_idle <= r_idle + TO_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_cnt <= '0;
    end else if ((w_hdr_last && (w_len == '0)) || w_done_c) begin
      r_cmd_cnt <= r_cmd_cnt + CNT_W'(1);
    end
  end

  pattern_beat_src #(
    .PKT_BYTES (PKT_BYTES)
  ) u_src (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start),
    .i_mode   (r_mode),
    .i_len    (w_len),
    .i_ready  (bus.o_tready),
    .o_valid  (bus.o_tvalid),
    .o_data   (bus.o_tdata),
    .o_keep   (bus.o_tkeep),
    .o_last   (bus.o_tlast),
    .o_done_c (w_done_c)
  );

  assign bus.i_tready = r_i_tready;
  assign busy         = r_busy;
  assign cmd_cnt      = r_cmd_cnt;

endmodule
